icache_refill_ctrl: RTL and testbench

- Direct-mapped instruction cache controller between the IF stage and the instruction ROM.
- Serves IF fetch requests and drives the cache-side handshake the flow controller consumes: Icache_ready_o for stall release, Icache_hit_o for jump-stop release.
- On a miss, issues a line refill request to the ROM and holds it until the ROM's ready pulse.
- Honours the flow controller's jump-stop so that refilled data from a squashed fetch is never returned to IF.

---
 rtl/icache_refill_ctrl_if.sv | 30 +++
 rtl/icache_refill_ctrl.sv | 113 +++++++++++
 tb/tb_icache_refill_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_if.sv
// Fetch-side and ROM-side signals of the instruction cache refill controller.
// The slave modport is the controller; the master modport is its environment.
interface icache_refill_ctrl_if #(
    parameter int WORDS_PER_LINE = 4
);
    logic                          if_valid_req_i;
    logic [31:0]                   if_pc_i;
    logic                          fc_jump_stop_Icache_i;
    logic                          Icache_ready_o;
    logic                          Icache_hit_o;
    logic [31:0]                   Icache_inst_o;
    logic                          rom_req_o;
    logic [31:0]                   rom_addr_o;
    logic                          rom_ready_i;
    logic [32*WORDS_PER_LINE-1:0]  rom_data_i;

    modport slave (
        input  if_valid_req_i, if_pc_i, fc_jump_stop_Icache_i,
        input  rom_ready_i, rom_data_i,
        output Icache_ready_o, Icache_hit_o, Icache_inst_o,
        output rom_req_o, rom_addr_o
    );

    modport master (
        output if_valid_req_i, if_pc_i, fc_jump_stop_Icache_i,
        output rom_ready_i, rom_data_i,
        input  Icache_ready_o, Icache_hit_o, Icache_inst_o,
        input  rom_req_o, rom_addr_o
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache: zero-latency hits, single outstanding
// line refill from ROM, squashed refills filled but never returned to IF.
module icache_refill_ctrl #(
    parameter int LINE_NUM       = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input logic                 clk,
    input logic                 rst,
    icache_refill_ctrl_if.slave bus
);
    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(LINE_NUM);
    localparam int IDX_LSB = OFF_W + 2;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;
    typedef logic [WORDS_PER_LINE-1:0][31:0] line_t;

    state_t              state_q, state_d;
    logic                abort_q;
    logic [31:0]         req_pc_q;
    logic [LINE_NUM-1:0] valid_q;
    logic [TAG_W-1:0]    tag_arr [LINE_NUM];
    line_t               data_arr [LINE_NUM];
    line_t               line_q;

    logic [OFF_W-1:0]    pc_off, req_off;
    logic [IDX_W-1:0]    pc_idx, req_idx;
    logic [TAG_W-1:0]    pc_tag, req_tag;
    logic                lookup_hit;
    logic                miss_req;
    logic                fill;
    logic                unused_pc_bits;

    assign pc_off  = bus.if_pc_i[IDX_LSB-1:2];
    assign pc_idx  = bus.if_pc_i[TAG_LSB-1:IDX_LSB];
    assign pc_tag  = bus.if_pc_i[31:TAG_LSB];
    assign req_off = req_pc_q[IDX_LSB-1:2];
    assign req_idx = req_pc_q[TAG_LSB-1:IDX_LSB];
    assign req_tag = req_pc_q[31:TAG_LSB];

    assign lookup_hit = valid_q[pc_idx] && (tag_arr[pc_idx] == pc_tag);
    assign miss_req   = (state_q == IDLE) && bus.if_valid_req_i && !lookup_hit;
    assign fill       = (state_q == REFILL) && bus.rom_ready_i;

    // Byte offset bits carry no information for word-aligned fetches.
    assign unused_pc_bits = ^{bus.if_pc_i[1:0], req_pc_q[1:0]};

    // Control state: FSM, sticky abort, latched miss address, valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            abort_q  <= 1'b0;
            req_pc_q <= '0;
            valid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (miss_req) req_pc_q <= bus.if_pc_i;
            if (fill) valid_q[req_idx] <= 1'b1;
            if (state_q == REFILL && !fill)
                abort_q <= abort_q | bus.fc_jump_stop_Icache_i;
            else
                abort_q <= 1'b0;
        end
    end

    // Tag/data arrays and the response line register; contents need no reset.
    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            tag_arr[req_idx]  <= req_tag;
            data_arr[req_idx] <= bus.rom_data_i;
            line_q            <= bus.rom_data_i;
        end
    end

    // Next-state and output decode; everything defaults to idle/zero.
    always_comb begin
        state_d            = state_q;
        bus.Icache_ready_o = 1'b0;
        bus.Icache_hit_o   = 1'b0;
        bus.Icache_inst_o  = '0;
        bus.rom_req_o      = 1'b0;
        bus.rom_addr_o     = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.if_valid_req_i) begin
                    if (lookup_hit) begin
                        bus.Icache_ready_o = 1'b1;
                        bus.Icache_hit_o   = 1'b1;
                        bus.Icache_inst_o  = data_arr[pc_idx][pc_off];
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                bus.rom_req_o  = 1'b1;
                bus.rom_addr_o = {req_pc_q[31:IDX_LSB], {IDX_LSB{1'b0}}};
                if (bus.rom_ready_i)
                    state_d = (abort_q || bus.fc_jump_stop_Icache_i) ? IDLE : RESP;
            end
            RESP: begin
                if (!bus.fc_jump_stop_Icache_i) begin
                    bus.Icache_ready_o = 1'b1;
                    bus.Icache_inst_o  = line_q[req_off];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scenario bench for icache_refill_ctrl: expected instructions are queued
// when a fetch is issued and compared when the cache reports ready.
module tb_icache_refill_ctrl;
    localparam int LN  = 16;
    localparam int WPL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    icache_refill_ctrl_if #(.WORDS_PER_LINE(WPL)) bus ();

    icache_refill_ctrl #(
        .LINE_NUM(LN),
        .WORDS_PER_LINE(WPL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mk_word(input logic [31:0] base, input int i);
        return {base[23:0], 8'(8'hA0 + i)};
    endfunction

    function automatic logic [32*WPL-1:0] mk_line(input logic [31:0] base);
        logic [32*WPL-1:0] l;
        for (int i = 0; i < WPL; i++) l[32*i +: 32] = mk_word(base, i);
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.if_valid_req_i        = 1'b0;
        bus.if_pc_i               = '0;
        bus.fc_jump_stop_Icache_i = 1'b0;
        bus.rom_ready_i           = 1'b0;
        bus.rom_data_i            = '0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic rom_reply(input logic [32*WPL-1:0] line, input int lat);
        repeat (lat - 1) step();
        bus.rom_ready_i = 1'b1;
        bus.rom_data_i  = line;
        step();
        bus.rom_ready_i = 1'b0;
        bus.rom_data_i  = '0;
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge clk);
        n_checks++;
        if ({bus.Icache_ready_o, bus.Icache_hit_o, bus.Icache_inst_o,
             bus.rom_req_o, bus.rom_addr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b hit=%b inst=%h req=%b addr=%h, required all 0",
                     bus.Icache_ready_o, bus.Icache_hit_o, bus.Icache_inst_o,
                     bus.rom_req_o, bus.rom_addr_o);
        end
    endtask

    task automatic test_cold_miss();
        logic [31:0] exp;
        bit seen;
        step();
        bus.if_valid_req_i = 1'b1;
        bus.if_pc_i        = 32'h0000_0108;
        exp_q.push_back(mk_word(32'h100, 2));
        @(negedge clk);
        n_checks++;
        if (bus.Icache_ready_o !== 1'b0 || bus.Icache_hit_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cold_lookup: rdy=%b hit=%b, required 0 0",
                     bus.Icache_ready_o, bus.Icache_hit_o);
        end
        step();
        bus.if_valid_req_i = 1'b0;
        bus.if_pc_i        = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (bus.rom_req_o !== 1'b1 || bus.rom_addr_o !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL cold_rom_req: req=%b addr=%h, required 1 00000100",
                     bus.rom_req_o, bus.rom_addr_o);
        end
        rom_reply(mk_line(32'h100), 5);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.Icache_ready_o === 1'b1) seen = 1'b1;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL cold_resp: no ready within 8 cycles, required inst %h", exp);
        end else if (bus.Icache_hit_o !== 1'b0 || bus.Icache_inst_o !== exp) begin
            n_fail++;
            $display("FAIL cold_resp: hit=%b inst=%h, required hit=0 inst=%h",
                     bus.Icache_hit_o, bus.Icache_inst_o, exp);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (bus.Icache_ready_o !== 1'b0 || bus.rom_req_o !== 1'b0 ||
            bus.Icache_inst_o !== 32'h0) begin
            n_fail++;
            $display("FAIL cold_idle: rdy=%b req=%b inst=%h, required 0 0 0",
                     bus.Icache_ready_o, bus.rom_req_o, bus.Icache_inst_o);
        end
    endtask

    task automatic test_hit();
        logic [31:0] exp;
        step();
        bus.if_valid_req_i        = 1'b1;
        bus.if_pc_i               = 32'h0000_010C;
        bus.fc_jump_stop_Icache_i = 1'b1;
        exp_q.push_back(mk_word(32'h100, 3));
        @(negedge clk);
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.Icache_ready_o !== 1'b1 || bus.Icache_hit_o !== 1'b1 ||
            bus.Icache_inst_o !== exp || bus.rom_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_same_cycle: rdy=%b hit=%b inst=%h req=%b, required 1 1 %h 0",
                     bus.Icache_ready_o, bus.Icache_hit_o, bus.Icache_inst_o,
                     bus.rom_req_o, exp);
        end
        step();
        bus.if_valid_req_i        = 1'b0;
        bus.fc_jump_stop_Icache_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rom_req_o !== 1'b0 || bus.Icache_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_no_refill: req=%b rdy=%b, required 0 0",
                     bus.rom_req_o, bus.Icache_ready_o);
        end
    endtask

    task automatic test_jump_stop();
        logic [31:0] exp;
        bit seen;
        step();
        bus.if_valid_req_i = 1'b1;
        bus.if_pc_i        = 32'h0000_0200;
        step();
        bus.if_valid_req_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rom_req_o !== 1'b1 || bus.rom_addr_o !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL js_rom_req: req=%b addr=%h, required 1 00000200",
                     bus.rom_req_o, bus.rom_addr_o);
        end
        step();
        bus.fc_jump_stop_Icache_i = 1'b1;
        step();
        bus.fc_jump_stop_Icache_i = 1'b0;
        step();
        bus.rom_ready_i = 1'b1;
        bus.rom_data_i  = mk_line(32'h200);
        step();
        bus.rom_ready_i = 1'b0;
        bus.rom_data_i  = '0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.Icache_ready_o !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen || bus.rom_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL js_squash: ready_seen=%b req=%b, required 0 0",
                     seen, bus.rom_req_o);
        end
        step();
        bus.if_valid_req_i = 1'b1;
        bus.if_pc_i        = 32'h0000_0204;
        exp_q.push_back(mk_word(32'h200, 1));
        @(negedge clk);
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.Icache_hit_o !== 1'b1 || bus.Icache_ready_o !== 1'b1 ||
            bus.Icache_inst_o !== exp) begin
            n_fail++;
            $display("FAIL js_filled_hit: hit=%b rdy=%b inst=%h, required 1 1 %h",
                     bus.Icache_hit_o, bus.Icache_ready_o, bus.Icache_inst_o, exp);
        end
        step();
        bus.if_valid_req_i = 1'b0;
    endtask

    task automatic test_conflict();
        logic [31:0] exp;
        bit seen;
        logic [31:0] pcs [2];
        pcs[0] = 32'h0000_0100;
        pcs[1] = 32'h0000_1100;
        for (int k = 0; k < 2; k++) begin
            step();
            bus.if_valid_req_i = 1'b1;
            bus.if_pc_i        = pcs[k];
            exp_q.push_back(mk_word(pcs[k], 0));
            step();
            bus.if_valid_req_i = 1'b0;
            @(negedge clk);
            n_checks++;
            if (bus.rom_req_o !== 1'b1 || bus.rom_addr_o !== pcs[k]) begin
                n_fail++;
                $display("FAIL conflict_req%0d: req=%b addr=%h, required 1 %h",
                         k, bus.rom_req_o, bus.rom_addr_o, pcs[k]);
            end
            rom_reply(mk_line(pcs[k]), 3);
            seen = 1'b0;
            for (int i = 0; i < 8 && !seen; i++) begin
                @(negedge clk);
                if (bus.Icache_ready_o === 1'b1) seen = 1'b1;
            end
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            n_checks++;
            if (!seen || bus.Icache_inst_o !== exp) begin
                n_fail++;
                $display("FAIL conflict_resp%0d: seen=%b inst=%h, required 1 %h",
                         k, seen, bus.Icache_inst_o, exp);
            end
        end
        step();
        bus.if_valid_req_i = 1'b1;
        bus.if_pc_i        = 32'h0000_0100;
        @(negedge clk);
        n_checks++;
        if (bus.Icache_hit_o !== 1'b0 || bus.Icache_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_evicted: hit=%b rdy=%b, required 0 0",
                     bus.Icache_hit_o, bus.Icache_ready_o);
        end
        step();
        bus.if_valid_req_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rom_req_o !== 1'b1 || bus.rom_addr_o !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL conflict_rerefill: req=%b addr=%h, required 1 00000100",
                     bus.rom_req_o, bus.rom_addr_o);
        end
        reset_dut();
    endtask

    task automatic test_reset_mid_refill();
        step();
        bus.if_valid_req_i = 1'b1;
        bus.if_pc_i        = 32'h0000_0300;
        step();
        bus.if_valid_req_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rom_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_req: req=%b, required 1", bus.rom_req_o);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rom_req_o !== 1'b0 || bus.rom_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_drop: req=%b addr=%h, required 0 00000000",
                     bus.rom_req_o, bus.rom_addr_o);
        end
        step();
        bus.rom_ready_i = 1'b1;
        bus.rom_data_i  = mk_line(32'h300);
        step();
        bus.rom_ready_i = 1'b0;
        bus.rom_data_i  = '0;
        bus.if_valid_req_i = 1'b1;
        bus.if_pc_i        = 32'h0000_0300;
        @(negedge clk);
        n_checks++;
        if (bus.Icache_hit_o !== 1'b0 || bus.Icache_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_late_ready: hit=%b rdy=%b, required 0 0",
                     bus.Icache_hit_o, bus.Icache_ready_o);
        end
        step();
        bus.if_valid_req_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rom_req_o !== 1'b1 || bus.rom_addr_o !== 32'h0000_0300) begin
            n_fail++;
            $display("FAIL rstmid_remiss: req=%b addr=%h, required 1 00000300",
                     bus.rom_req_o, bus.rom_addr_o);
        end
        reset_dut();
    endtask

    task automatic test_spurious();
        logic [31:0] exp;
        bit seen;
        step();
        bus.if_valid_req_i = 1'b1;
        bus.if_pc_i        = 32'h0000_0508;
        exp_q.push_back(mk_word(32'h500, 2));
        step();
        bus.if_valid_req_i = 1'b0;
        rom_reply(mk_line(32'h500), 2);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.Icache_ready_o === 1'b1) seen = 1'b1;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_checks++;
        if (!seen || bus.Icache_inst_o !== exp) begin
            n_fail++;
            $display("FAIL spur_fill: seen=%b inst=%h, required 1 %h",
                     seen, bus.Icache_inst_o, exp);
        end
        step();
        step();
        bus.rom_ready_i = 1'b1;
        bus.rom_data_i  = mk_line(32'hBAD00);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.Icache_ready_o, bus.Icache_hit_o, bus.Icache_inst_o,
                 bus.rom_req_o, bus.rom_addr_o} !== '0) begin
                n_fail++;
                $display("FAIL spur_outputs%0d: rdy=%b hit=%b inst=%h req=%b addr=%h, required all 0",
                         c, bus.Icache_ready_o, bus.Icache_hit_o, bus.Icache_inst_o,
                         bus.rom_req_o, bus.rom_addr_o);
            end
            step();
            bus.rom_ready_i = 1'b0;
            bus.rom_data_i  = '0;
        end
        bus.if_valid_req_i = 1'b1;
        bus.if_pc_i        = 32'h0000_050C;
        exp_q.push_back(mk_word(32'h500, 3));
        @(negedge clk);
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.Icache_hit_o !== 1'b1 || bus.Icache_inst_o !== exp) begin
            n_fail++;
            $display("FAIL spur_line_kept: hit=%b inst=%h, required 1 %h",
                     bus.Icache_hit_o, bus.Icache_inst_o, exp);
        end
        step();
        bus.if_valid_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_jump_stop();
        test_conflict();
        test_reset_mid_refill();
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
